pipe_ctrl: RTL

Parametrised pipeline hazard/stall controller for the in-order MIPS core; successor to the fixed five-stage stall logic. Owns per-stage valid bits and derives stall, bubble and flush for an N-stage pipe. Tracks outstanding data-bus transactions so MEM waits on the correct response. Sits beside the datapath; every stage register uses its `stage_stall` and `stage_valid`.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipe_ctrl_outst_cnt.sv | 50 +++++
 rtl/pipe_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: default stage indices and counter width helper.
package pipe_ctrl_pkg;

  localparam int unsigned IF_STG  = 0;
  localparam int unsigned ID_STG  = 1;
  localparam int unsigned EXE_STG = 2;
  localparam int unsigned MEM_STG = 3;
  localparam int unsigned WB_STG  = 4;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_outst_cnt.sv
// Saturating up/down counter of accepted-but-unanswered data requests, with sticky
// detection of responses that arrive while nothing is outstanding.
module pipe_ctrl_outst_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             req_acc,
  input  logic                             rsp,
  output logic [cnt_width(MAX_OUTST)-1:0]  cnt,
  output logic                             proto_err
);

  localparam int unsigned CNT_W = cnt_width(MAX_OUTST);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             proto_err_q, proto_err_d;
  logic             dec;

  // A response only retires a request if one is outstanding.
  always_comb begin
    cnt_d       = cnt_q;
    proto_err_d = proto_err_q;
    dec         = rsp && (cnt_q != '0);
    if (rsp && (cnt_q == '0)) begin
      proto_err_d = 1'b1;
    end
    if (req_acc && !dec && (cnt_q != CNT_W'(MAX_OUTST))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !req_acc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign cnt       = cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/bubble/flush and per-stage valid control for an N-stage in-order pipe.
// Optional stall watchdog enabled by defining PIPE_CTRL_WDOG_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STAGES     = WB_STG + 1,
  parameter int unsigned MEM_STAGE  = MEM_STG,
  parameter int unsigned MAX_OUTST  = 2,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             if_valid,
  input  logic [STAGES-1:0]                stall_req,
  input  logic [STAGES-1:0]                flush_req,
  input  logic                             mem_access,
  input  logic                             data_req,
  input  logic                             data_addr_ok,
  input  logic                             data_data_ok,
  output logic [STAGES-1:0]                stage_stall,
  output logic [STAGES-1:0]                stage_valid,
  output logic                             fetch_kill,
  output logic                             data_req_allow,
  output logic [cnt_width(MAX_OUTST)-1:0]  data_outst,
  output logic                             proto_err,
  output logic                             wdog_timeout
);

  localparam int unsigned CNT_W = cnt_width(MAX_OUTST);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] ls;
  logic [STAGES-1:0] kill;
  logic [CNT_W-1:0]  outst;

  pipe_ctrl_outst_cnt #(
    .MAX_OUTST (MAX_OUTST)
  ) u_outst_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .req_acc   (data_req && data_addr_ok),
    .rsp       (data_data_ok),
    .cnt       (outst),
    .proto_err (proto_err)
  );

  // Local stall terms, then cascade so any later stall freezes earlier stages.
  always_comb begin
    ls                = stall_req;
    ls[MEM_STAGE-1]   = ls[MEM_STAGE-1] | (data_req && !data_addr_ok);
    ls[MEM_STAGE]     = ls[MEM_STAGE] |
                        (valid_q[MEM_STAGE] && mem_access && !((outst != '0) && data_data_ok));
    stage_stall            = '0;
    stage_stall[STAGES-1]  = ls[STAGES-1];
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      stage_stall[i] = ls[i] | stage_stall[i+1];
    end
  end

  // A flush at stage k kills every stage below k.
  always_comb begin
    kill           = '0;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      kill[i] = kill[i+1] | flush_req[i+1];
    end
    fetch_kill = |flush_req;
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < int'(STAGES); i++) begin
      if (kill[i]) begin
        valid_d[i] = 1'b0;
      end else if (!stage_stall[i]) begin
        if (i == int'(IF_STG)) begin
          valid_d[i] = if_valid;
        end else begin
          valid_d[i] = valid_q[i-1] && !stage_stall[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign stage_valid    = valid_q;
  assign data_outst     = outst;
  assign data_req_allow = (outst < CNT_W'(MAX_OUTST));

`ifdef PIPE_CTRL_WDOG_EN
  localparam int unsigned WDOG_W = cnt_width(WDOG_LIMIT);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_q, wdog_d;

  // Count consecutive cycles the stage ahead of WB is held; saturate at the limit.
  always_comb begin
    wdog_cnt_d = '0;
    wdog_d     = wdog_q;
    if (stage_stall[STAGES-2]) begin
      wdog_cnt_d = wdog_cnt_q;
      if (wdog_cnt_q != WDOG_W'(WDOG_LIMIT)) begin
        wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
      end
    end
    if (wdog_cnt_d == WDOG_W'(WDOG_LIMIT)) begin
      wdog_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt_q <= '0;
      wdog_q     <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_q     <= wdog_d;
    end
  end

  assign wdog_timeout = wdog_q;
`else
  logic unused_wdog;
  assign unused_wdog  = (WDOG_LIMIT == 0);
  assign wdog_timeout = 1'b0;
`endif

endmodule
